// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types and constants for the note sequencer
//
// Purpose: note-code constants understood by the DAC SPI master, the
// sequencer state encoding and the song entry layout.
// Ports: none (package).
package note_pkg;

  localparam int NOTE_W     = 6;
  localparam int NOTE_DUR_W = 8;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [NOTE_W-1:0] NOTE_A1   = 6'd1;
  localparam logic [NOTE_W-1:0] NOTE_A1S  = 6'd2;
  localparam logic [NOTE_W-1:0] NOTE_B1   = 6'd3;
  localparam logic [NOTE_W-1:0] NOTE_C1   = 6'd4;
  localparam logic [NOTE_W-1:0] NOTE_C1S  = 6'd5;
  localparam logic [NOTE_W-1:0] NOTE_D1   = 6'd6;
  localparam logic [NOTE_W-1:0] NOTE_D1S  = 6'd7;
  localparam logic [NOTE_W-1:0] NOTE_E1   = 6'd8;
  localparam logic [NOTE_W-1:0] NOTE_F1   = 6'd9;
  localparam logic [NOTE_W-1:0] NOTE_F1S  = 6'd10;
  localparam logic [NOTE_W-1:0] NOTE_G1   = 6'd11;
  localparam logic [NOTE_W-1:0] NOTE_G1S  = 6'd12;
  localparam logic [NOTE_W-1:0] NOTE_A2   = 6'd13;
  localparam logic [NOTE_W-1:0] NOTE_B2   = 6'd14;
  localparam logic [NOTE_W-1:0] NOTE_C2   = 6'd15;
  localparam logic [NOTE_W-1:0] NOTE_D2   = 6'd16;
  localparam logic [NOTE_W-1:0] NOTE_E2   = 6'd17;
  localparam logic [NOTE_W-1:0] NOTE_F2   = 6'd18;
  localparam logic [NOTE_W-1:0] NOTE_G2   = 6'd19;
  localparam logic [NOTE_W-1:0] NOTE_F4H  = 6'd20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  // Layout of one song RAM word: note code in the upper bits, duration below.
  typedef struct packed {
    logic [NOTE_W-1:0]     note;
    logic [NOTE_DUR_W-1:0] dur;
  } song_entry_t;

endpackage

// File: rtl/song_ram.sv
// rtl/song_ram.sv - single-write-port, synchronous-read song memory
//
// Purpose: holds DEPTH song entries of DW bits; contents are never reset.
// Ports:
//   i_clk      - clock
//   i_wr_en    - write strobe (already qualified by the caller)
//   i_wr_addr  - write address
//   i_wr_data  - packed {note, dur} entry to store
//   i_rd_addr  - read address, sampled every cycle
//   o_rd_data  - registered read data, one cycle after i_rd_addr
module song_ram #(
  parameter int DEPTH = 32,
  parameter int DW    = 14
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DW-1:0]            o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - programmable melody sequencer driving the DAC SPI master
//
// Purpose: plays song RAM entries {note, dur} in order, holding each note for
// dur*TICK_DIV cycles followed by GAP_CYCLES of silence, with start/stop/loop.
// Ports:
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_wr_en/addr/note/dur  - song RAM write port, honoured only while idle
//   i_start                - level-sampled start, acted on only in IDLE
//   i_stop                 - abort playback, back to IDLE next cycle
//   i_loop_en              - wrap to entry 0 at end of song instead of finishing
//   o_note_state           - note code to the SPI master
//   o_button_action        - key-down to the SPI master
//   o_busy                 - playback in progress
//   o_done                 - one-cycle pulse on normal completion
//   o_cur_index            - entry being fetched or played
module note_sequencer
  import note_pkg::*;
#(
  parameter int SONG_LEN   = 32,
  parameter int DUR_W      = 8,
  parameter int TICK_DIV   = 1_000_000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [$clog2(SONG_LEN)-1:0] i_wr_addr,
  input  logic [NOTE_W-1:0]           i_wr_note,
  input  logic [DUR_W-1:0]            i_wr_dur,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_loop_en,
  output logic [NOTE_W-1:0]           o_note_state,
  output logic                        o_button_action,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [$clog2(SONG_LEN)-1:0] o_cur_index
);

  localparam int AW = $clog2(SONG_LEN);
  localparam int DW = NOTE_W + DUR_W;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(SONG_LEN - 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nx;
  logic [AW-1:0]     r_cur_index;
  logic [AW-1:0]     w_idx_nx;
  logic [PW-1:0]     r_presc;
  logic [DUR_W-1:0]  r_tick;
  logic [DUR_W-1:0]  r_dur;
  logic [GW-1:0]     r_gap;
  logic [NOTE_W-1:0] r_note;
  logic              r_button;
  logic              r_busy;
  logic              r_done;

  logic [NOTE_W-1:0] w_note_nx;
  logic              w_button_nx;
  logic              w_busy_nx;
  logic              w_done_nx;

  logic [DW-1:0]     w_rd_data;
  logic [NOTE_W-1:0] w_rd_note;
  logic [DUR_W-1:0]  w_rd_dur;
  logic              w_play_end;
  logic              w_gap_end;
  logic              w_ram_we;

  assign w_ram_we  = i_wr_en && (r_state == S_IDLE);
  assign w_rd_note = w_rd_data[DW-1:DUR_W];
  assign w_rd_dur  = w_rd_data[DUR_W-1:0];

  // The read address is the registered index, so it is already valid in FETCH
  // and the entry arrives in LATCH.
  song_ram #(
    .DEPTH (SONG_LEN),
    .DW    (DW)
  ) u_song_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (i_wr_addr),
    .i_wr_data ({i_wr_note, i_wr_dur}),
    .i_rd_addr (r_cur_index),
    .o_rd_data (w_rd_data)
  );

  // Nested counters: prescaler wraps every TICK_DIV cycles, tick counts up to dur.
  assign w_play_end = (r_presc == PRESC_MAX) && (r_tick == (r_dur - 1'b1));
  assign w_gap_end  = (r_gap == GAP_MAX);

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cur_index <= '0;
      r_note      <= '0;
      r_button    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cur_index <= w_idx_nx;
      r_note      <= w_note_nx;
      r_button    <= w_button_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  // Duration and gap counters; both sit at zero outside their own state so
  // each PLAY/GAP starts from a clean count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_tick  <= '0;
      r_dur   <= '0;
      r_gap   <= '0;
    end else begin
      if (r_state == S_LATCH) begin
        r_dur <= w_rd_dur;
      end
      if (r_state != S_PLAY) begin
        r_presc <= '0;
        r_tick  <= '0;
      end else if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_tick  <= r_tick + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (r_state != S_GAP) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_cur_index;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nx = S_FETCH;
          w_idx_nx   = '0;
        end
      end
      S_FETCH: w_state_nx = S_LATCH;
      S_LATCH: begin
        if (w_rd_dur != '0) begin
          w_state_nx = S_PLAY;
        end else if (i_loop_en) begin
          w_state_nx = S_FETCH;
          w_idx_nx   = '0;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      S_PLAY: begin
        if (w_play_end) begin
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          if (r_cur_index != LAST_IDX) begin
            w_state_nx = S_FETCH;
            w_idx_nx   = r_cur_index + 1'b1;
          end else if (i_loop_en) begin
            w_state_nx = S_FETCH;
            w_idx_nx   = '0;
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Stop wins over everything else once playback has begun.
    if (i_stop && (r_state != S_IDLE)) begin
      w_state_nx = S_IDLE;
      w_idx_nx   = r_cur_index;
    end
  end

  // Output logic, evaluated on the next state so the outputs come out of flops.
  always_comb begin
    w_note_nx   = r_note;
    w_button_nx = 1'b0;
    w_busy_nx   = 1'b1;
    w_done_nx   = 1'b0;
    case (w_state_nx)
      S_IDLE: begin
        w_note_nx = '0;
        w_busy_nx = 1'b0;
      end
      S_DONE: begin
        w_note_nx = '0;
        w_busy_nx = 1'b0;
        w_done_nx = 1'b1;
      end
      S_PLAY: begin
        if (r_state == S_LATCH) begin
          w_note_nx   = w_rd_note;
          w_button_nx = (w_rd_note != NOTE_REST);
        end else begin
          w_button_nx = r_button;
        end
      end
      default: ;
    endcase
  end

  assign o_note_state    = r_note;
  assign o_button_action = r_button;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_cur_index     = r_cur_index;

endmodule
